// File: rtl/eth_arp_rx_multi.sv
// ARP receive parser for an 8-bit GMII RX stream. It answers for several local IPs,
// can skip one 802.1Q tag and can check the FCS. Results are released only after the
// frame has ended.
module eth_arp_rx_multi #(
  parameter logic [47:0]          BOARD_MAC     = 48'h00_11_22_33_44_55,
  parameter int                   NUM_IP        = 2,
  parameter logic [NUM_IP*32-1:0] BOARD_IP_LIST = 64'hC0A8010B_C0A8010A,
  parameter bit                   VLAN_EN       = 1'b1,
  parameter bit                   FCS_CHECK_EN  = 1'b1,
  parameter int                   MAX_LEN       = 1522
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_drop,
  output logic        arp_rx_type,
  output logic        arp_gratuitous,
  output logic [2:0]  ip_hit_idx,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  typedef enum logic [3:0] {
    WAIT_IFG, IDLE, PREAMBLE, ETH_HEAD, VLAN, ARP_DATA, TAIL, CHECK, DROP
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;          // byte index after the SFD
  logic [4:0]  fld_q, fld_d;          // preamble count, VLAN offset or ARP offset
  logic [7:0]  prev_q, prev_d;        // previous byte, for 16-bit fields
  logic [31:0] crc_q, crc_d;
  logic        ucast_q, ucast_d, bcast_q, bcast_d, err_q, err_d;
  logic        oper2_q, oper2_d, grat_q, grat_d;
  logic [2:0]  idx_q, idx_d;
  logic [47:0] cap_mac_q, cap_mac_d;
  logic [31:0] cap_ip_q, cap_ip_d;
  logic [23:0] tip_q, tip_d;          // first three target-IP bytes
  logic        done_q, done_d, drop_q, drop_d, type_q, type_d, gout_q, gout_d;
  logic [2:0]  iout_q, iout_d;
  logic [47:0] smac_q, smac_d;
  logic [31:0] sip_q, sip_d;
  logic [31:0] tip_full;
  logic        ip_hit;
  logic [2:0]  ip_idx;

  // Reflected CRC-32 update for one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  // Byte i of BOARD_MAC in wire order (byte 0 is the most significant).
  function automatic logic [7:0] mac_byte(input logic [2:0] i);
    logic [47:0] m;
    m = BOARD_MAC << (8 * i);
    return m[47:40];
  endfunction

  // Compare the complete target IP with every local IP; the lowest matching index wins.
  always_comb begin
    tip_full = {tip_q, gmii_rxd};
    ip_hit   = 1'b0;
    ip_idx   = '0;
    for (int k = NUM_IP - 1; k >= 0; k--) begin
      if (BOARD_IP_LIST[32*k +: 32] == tip_full) begin
        ip_hit = 1'b1;
        ip_idx = 3'(k);
      end
    end
  end

  // Next-state and datapath logic for the receive FSM.
  always_comb begin
    // NOTE: every _d starts from its _q (or 0 for pulses) so no path leaves a latch.
    state_d = state_q;  cnt_d = cnt_q;  fld_d = fld_q;  prev_d = prev_q;  crc_d = crc_q;
    ucast_d = ucast_q;  bcast_d = bcast_q;  err_d = err_q;  oper2_d = oper2_q;
    grat_d = grat_q;  idx_d = idx_q;  cap_mac_d = cap_mac_q;  cap_ip_d = cap_ip_q;
    tip_d = tip_q;  done_d = 1'b0;  drop_d = 1'b0;  type_d = type_q;  gout_d = gout_q;
    iout_d = iout_q;  smac_d = smac_q;  sip_d = sip_q;

    unique case (state_q)
      WAIT_IFG: if (!gmii_rx_dv) state_d = IDLE;
      IDLE: if (gmii_rx_dv) begin
        state_d = (gmii_rxd == 8'h55) ? PREAMBLE : WAIT_IFG;
        fld_d   = '0;
      end
      PREAMBLE: begin
        if (gmii_rx_dv && gmii_rxd == 8'h55 && fld_q < 5'd6) begin
          fld_d = fld_q + 5'd1;
        end else if (gmii_rx_dv && gmii_rxd == 8'hD5 && fld_q == 5'd6) begin
          state_d = ETH_HEAD;  cnt_d = '0;  crc_d = '1;
          ucast_d = 1'b1;  bcast_d = 1'b1;  err_d = 1'b0;
        end else begin
          state_d = WAIT_IFG;
        end
      end
      ETH_HEAD, VLAN, ARP_DATA, TAIL: begin
        if (!gmii_rx_dv) begin
          state_d = (state_q == TAIL) ? CHECK : DROP;
        end else if (gmii_rx_er || cnt_q >= 11'(MAX_LEN)) begin
          state_d = DROP;
        end else begin
          cnt_d  = cnt_q + 11'd1;
          crc_d  = crc32_byte(crc_q, gmii_rxd);
          prev_d = gmii_rxd;
          fld_d  = fld_q + 5'd1;
          if (state_q == ETH_HEAD) begin
            if (cnt_q < 11'd6) begin
              ucast_d = ucast_q && (gmii_rxd == mac_byte(cnt_q[2:0]));
              bcast_d = bcast_q && (gmii_rxd == 8'hFF);
            end
            if (cnt_q == 11'd6 && !(ucast_q || bcast_q)) state_d = DROP;
            if (cnt_q == 11'd13) begin
              fld_d = '0;
              if ({prev_q, gmii_rxd} == 16'h0806) state_d = ARP_DATA;
              else if (VLAN_EN && {prev_q, gmii_rxd} == 16'h8100) state_d = VLAN;
              else state_d = DROP;
            end
          end else if (state_q == VLAN) begin
            if (fld_q == 5'd3) begin
              fld_d   = '0;
              state_d = ({prev_q, gmii_rxd} == 16'h0806) ? ARP_DATA : DROP;
            end
          end else if (state_q == ARP_DATA) begin
            case (fld_q) inside
              5'd1: if ({prev_q, gmii_rxd} != 16'h0001) err_d = 1'b1;
              5'd3: if ({prev_q, gmii_rxd} != 16'h0800) err_d = 1'b1;
              5'd4: if (gmii_rxd != 8'h06) err_d = 1'b1;
              5'd5: if (gmii_rxd != 8'h04) err_d = 1'b1;
              5'd7: begin
                if ({prev_q, gmii_rxd} == 16'h0001)      oper2_d = 1'b0;
                else if ({prev_q, gmii_rxd} == 16'h0002) oper2_d = 1'b1;
                else                                     err_d   = 1'b1;
              end
              [5'd8:5'd13]:  cap_mac_d = {cap_mac_q[39:0], gmii_rxd};
              [5'd14:5'd17]: cap_ip_d  = {cap_ip_q[23:0], gmii_rxd};
              [5'd24:5'd26]: tip_d     = {tip_q[15:0], gmii_rxd};
              5'd27: begin
                state_d = TAIL;
                idx_d   = ip_idx;
                grat_d  = (cap_ip_q == tip_full);
                if (!ip_hit) err_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!err_q && (!FCS_CHECK_EN || crc_q == 32'hDEBB_20E3)) begin
          done_d = 1'b1;  smac_d = cap_mac_q;  sip_d = cap_ip_q;
          type_d = oper2_q;  gout_d = grat_q;  iout_d = idx_q;
        end else begin
          drop_d = 1'b1;
        end
      end
      DROP: if (!gmii_rx_dv) state_d = IDLE;
      default: state_d = WAIT_IFG;
    endcase

    if (state_d == DROP && state_q != DROP) drop_d = 1'b1;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= WAIT_IFG;  cnt_q <= '0;  fld_q <= '0;  prev_q <= '0;  crc_q <= '0;
      ucast_q <= 1'b0;  bcast_q <= 1'b0;  err_q <= 1'b0;  oper2_q <= 1'b0;  grat_q <= 1'b0;
      idx_q <= '0;  cap_mac_q <= '0;  cap_ip_q <= '0;  tip_q <= '0;
      done_q <= 1'b0;  drop_q <= 1'b0;  type_q <= 1'b0;  gout_q <= 1'b0;  iout_q <= '0;
      smac_q <= '0;  sip_q <= '0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  fld_q <= fld_d;  prev_q <= prev_d;  crc_q <= crc_d;
      ucast_q <= ucast_d;  bcast_q <= bcast_d;  err_q <= err_d;  oper2_q <= oper2_d;
      grat_q <= grat_d;  idx_q <= idx_d;  cap_mac_q <= cap_mac_d;  cap_ip_q <= cap_ip_d;
      tip_q <= tip_d;  done_q <= done_d;  drop_q <= drop_d;  type_q <= type_d;
      gout_q <= gout_d;  iout_q <= iout_d;  smac_q <= smac_d;  sip_q <= sip_d;
    end
  end

  assign arp_rx_done    = done_q;
  assign arp_rx_drop    = drop_q;
  assign arp_rx_type    = type_q;
  assign arp_gratuitous = gout_q;
  assign ip_hit_idx     = iout_q;
  assign src_mac        = smac_q;
  assign src_ip         = sip_q;

endmodule

// File: tb/tb_eth_arp_rx_multi.sv
// Directed bench for eth_arp_rx_multi: table of ARP frames plus a mid-frame reset sequence.
// A second instance with the FCS check disabled sees the same stimulus.
module tb_eth_arp_rx_multi;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;

  logic        clk = 1'b0;
  logic        rst, gmii_rx_dv, gmii_rx_er;
  logic [7:0]  gmii_rxd;
  logic        arp_rx_done, arp_rx_drop, arp_rx_type, arp_gratuitous;
  logic [2:0]  ip_hit_idx;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic        d2_done, d2_drop, d2_type, d2_grat;
  logic [2:0]  d2_idx;
  logic [47:0] d2_mac;
  logic [31:0] d2_ip;

  always #4 clk = ~clk;

  eth_arp_rx_multi dut (
    .clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
    .arp_rx_done(arp_rx_done), .arp_rx_drop(arp_rx_drop), .arp_rx_type(arp_rx_type),
    .arp_gratuitous(arp_gratuitous), .ip_hit_idx(ip_hit_idx), .src_mac(src_mac), .src_ip(src_ip)
  );

  eth_arp_rx_multi #(.FCS_CHECK_EN(1'b0)) dut_nofcs (
    .clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
    .arp_rx_done(d2_done), .arp_rx_drop(d2_drop), .arp_rx_type(d2_type),
    .arp_gratuitous(d2_grat), .ip_hit_idx(d2_idx), .src_mac(d2_mac), .src_ip(d2_ip)
  );

  typedef struct {
    logic [47:0] dst;
    bit          vlan;
    logic [15:0] etype;
    logic [15:0] oper;
    logic [7:0]  plen;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    bit          bad_fcs;
    int          er_at;      // frame byte index with rx_er, -1 none
    int          cut_at;     // frame byte index where dv falls early, -1 none
    int          total_len;  // bytes after SFD including FCS
    bit          exp_done;
    bit          exp_done2;  // expectation for the instance without FCS check
    bit          exp_type;
    logic [2:0]  exp_idx;
    bit          exp_grat;
  } vec_t;

  vec_t        vecs[13];
  logic [7:0]  frm[$];
  int          n_vec = 0, n_err = 0;
  int          done_cnt, drop_cnt, both_cnt, done2_cnt;
  bit          mon_en = 1'b0;
  logic        done_n1;
  logic        m_type, m_grat;
  logic [2:0]  m_idx;
  logic [47:0] m_mac;
  logic [31:0] m_ip;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse counters, sampled on the falling edge away from the DUT's active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (arp_rx_done) done_cnt++;
      if (arp_rx_drop) drop_cnt++;
      if (arp_rx_done && arp_rx_drop) both_cnt++;
      if (d2_done) done2_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  task automatic push_bytes(input logic [63:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(val[8*i +: 8]);
  endtask

  task automatic build(input vec_t v);
    logic [31:0] c;
    frm.delete();
    push_bytes(v.dst, 6);  push_bytes(v.sha, 6);
    if (v.vlan) push_bytes(32'h8100_0005, 4);
    push_bytes(v.etype, 2);
    push_bytes(16'h0001, 2);  push_bytes(16'h0800, 2);  push_bytes(8'h06, 1);
    push_bytes(v.plen, 1);  push_bytes(v.oper, 2);  push_bytes(v.sha, 6);
    push_bytes(v.spa, 4);  push_bytes(48'd0, 6);  push_bytes(v.tpa, 4);
    while (frm.size() < v.total_len - 4) frm.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) c = crc_upd(c, frm[i]);
    c = ~c;
    if (v.bad_fcs) c[0] = ~c[0];
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d, input logic r);
    @(negedge clk);
    gmii_rx_dv = dv;  gmii_rx_er = er;  gmii_rxd = d;  rst = r;
  endtask

  // Preamble, SFD, frame bytes, then the first dv=0 cycle. rst_at asserts rst for 3 bytes.
  task automatic send_frame(input int er_at, input int cut_at, input int rst_at);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, (i == 7) ? 8'hD5 : 8'h55, 1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == cut_at) break;
      drive(1'b1, i == er_at, frm[i], rst_at >= 0 && i >= rst_at && i < rst_at + 3);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic run_frame(input int er_at, input int cut_at, input int rst_at);
    done_cnt = 0;  drop_cnt = 0;  both_cnt = 0;  done2_cnt = 0;  mon_en = 1'b1;
    send_frame(er_at, cut_at, rst_at);
    @(negedge clk);
    @(negedge clk);
    done_n1 = arp_rx_done;       // one cycle after the DUT first saw dv=0
    repeat (9) @(negedge clk);   // 12-cycle gap in total
    mon_en = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " type"}, 64'(arp_rx_type), 64'(m_type));
    check({tag, " idx"},  64'(ip_hit_idx), 64'(m_idx));
    check({tag, " grat"}, 64'(arp_gratuitous), 64'(m_grat));
    check({tag, " src_mac"}, 64'(src_mac), 64'(m_mac));
    check({tag, " src_ip"},  64'(src_ip), 64'(m_ip));
  endtask

  task automatic apply(input int n, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", n);
    build(v);
    run_frame(v.er_at, v.cut_at, -1);
    check({tag, " done_cnt"}, 64'(done_cnt), 64'(v.exp_done));
    check({tag, " drop_cnt"}, 64'(drop_cnt), 64'(!v.exp_done));
    check({tag, " done_and_drop"}, 64'(both_cnt), 64'd0);
    check({tag, " nofcs_done_cnt"}, 64'(done2_cnt), 64'(v.exp_done2));
    if (v.exp_done) begin
      check({tag, " done_at_n1"}, 64'(done_n1), 64'd1);
      m_type = v.exp_type;  m_idx = v.exp_idx;  m_grat = v.exp_grat;
      m_mac = v.sha;  m_ip = v.spa;
    end
    check_outputs(tag);
  endtask

  function automatic vec_t base();
    vec_t v;
    v.dst = 48'hFFFF_FFFF_FFFF;  v.vlan = 1'b0;  v.etype = 16'h0806;  v.oper = 16'h0001;
    v.plen = 8'h04;  v.sha = 48'h000A_3501_0203;  v.spa = 32'hC0A8_0102;
    v.tpa = 32'hC0A8_010A;  v.bad_fcs = 1'b0;  v.er_at = -1;  v.cut_at = -1;
    v.total_len = 64;  v.exp_done = 1'b1;  v.exp_done2 = 1'b1;  v.exp_type = 1'b0;
    v.exp_idx = 3'd0;  v.exp_grat = 1'b0;
    return v;
  endfunction

  initial begin
    vec_t v;
    v = base();  vecs[0] = v;                                   // broadcast request to .10
    v = base();  v.dst = BOARD_MAC;  v.vlan = 1'b1;  v.oper = 16'h0002;
    v.tpa = 32'hC0A8_010B;  v.sha = 48'h00AA_BBCC_DDEE;  v.spa = 32'hC0A8_0105;
    v.exp_type = 1'b1;  v.exp_idx = 3'd1;  vecs[1] = v;         // VLAN unicast reply to .11
    v = base();  v.bad_fcs = 1'b1;  v.exp_done = 1'b0;  vecs[2] = v;   // FCS bit flipped
    v = base();  v.tpa = 32'hC0A8_0163;  v.exp_done = 1'b0;  v.exp_done2 = 1'b0;  vecs[3] = v;
    v = base();  v.oper = 16'h0003;  v.exp_done = 1'b0;  v.exp_done2 = 1'b0;  vecs[4] = v;
    v = base();  v.plen = 8'h06;  v.exp_done = 1'b0;  v.exp_done2 = 1'b0;  vecs[5] = v;
    v = base();  v.dst = 48'h0011_2233_4456;  v.exp_done = 1'b0;  v.exp_done2 = 1'b0;  vecs[6] = v;
    v = base();  v.er_at = 14 + 10;  v.exp_done = 1'b0;  v.exp_done2 = 1'b0;  vecs[7] = v;
    v = base();  v.cut_at = 14 + 20;  v.exp_done = 1'b0;  v.exp_done2 = 1'b0;  vecs[8] = v;
    v = base();  v.total_len = 1600;  v.exp_done = 1'b0;  v.exp_done2 = 1'b0;  vecs[9] = v;
    v = base();  v.etype = 16'h0800;  v.exp_done = 1'b0;  v.exp_done2 = 1'b0;  vecs[10] = v;
    v = base();  v.sha = 48'h000A_35AA_BBCC;  v.spa = 32'hC0A8_0103;  v.tpa = 32'hC0A8_010B;
    v.exp_idx = 3'd1;  vecs[11] = v;                            // recovery after errors
    v = base();  v.sha = 48'h000A_350A_0B0C;  v.spa = 32'hC0A8_010A;
    v.exp_grat = 1'b1;  vecs[12] = v;                           // gratuitous ARP

    rst = 1'b1;  gmii_rx_dv = 1'b0;  gmii_rx_er = 1'b0;  gmii_rxd = 8'h00;
    m_type = 1'b0;  m_idx = '0;  m_grat = 1'b0;  m_mac = '0;  m_ip = '0;
    repeat (4) @(negedge clk);
    check("reset done", 64'(arp_rx_done), 64'd0);
    check("reset drop", 64'(arp_rx_drop), 64'd0);
    check_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 13; i++) apply(i, vecs[i]);

    // Reset while a frame is being received: no pulses, outputs cleared, next frame accepted.
    build(vecs[0]);
    run_frame(-1, -1, 20);
    check("midrst done_cnt", 64'(done_cnt), 64'd0);
    check("midrst drop_cnt", 64'(drop_cnt), 64'd0);
    check("midrst nofcs_done_cnt", 64'(done2_cnt), 64'd0);
    m_type = 1'b0;  m_idx = '0;  m_grat = 1'b0;  m_mac = '0;  m_ip = '0;
    check_outputs("midrst");
    apply(13, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
